// File: rtl/jtframe_st_dump_pkg.sv
// Shared definitions for the status-bus dumper: FSM states, ASCII constants
// and the nibble-to-hex-character helper.
package jtframe_st_dump_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CAPTURE, S_HI, S_LO, S_SP, S_CR, S_LF
  } state_t;

  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? ASC_0 + {4'h0, n} : ASC_A + {4'h0, n} - 8'd10;
  endfunction
endpackage

// File: rtl/jtframe_uart_tx_byte.sv
// 8N1 UART transmitter, LSB first. One byte per load; ready is high only while idle.
module jtframe_uart_tx_byte #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       ready,
  output logic       tx
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [8:0]    sh;
  logic          active;

  assign ready = ~active;

  // sh holds the bits still to go out after the start bit: 8 data + stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      tx     <= 1'b1;
      cnt    <= '0;
      bitn   <= '0;
      sh     <= '1;
    end else if (!active) begin
      if (load) begin
        active <= 1'b1;
        tx     <= 1'b0;
        sh     <= {1'b1, din};
        bitn   <= 4'd9;
        cnt    <= RELOAD;
      end
    end else if (cnt == '0) begin
      cnt <= RELOAD;
      if (bitn == 4'd0) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        tx   <= sh[0];
        sh   <= {1'b1, sh[8:1]};
        bitn <= bitn - 4'd1;
      end
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/jtframe_st_dump.sv
// Sweeps the status bus on request and streams each byte as "HH " over UART,
// terminating the line with CR LF.
module jtframe_st_dump
  import jtframe_st_dump_pkg::*;
#(
  parameter int         CLK_DIV    = 434,
  parameter logic [7:0] ADDR_FIRST = 8'h00,
  parameter logic [7:0] ADDR_LAST  = 8'hFF,
  parameter int         SETTLE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] st_dout,
  output logic [7:0] st_addr,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);
  localparam int SW = $clog2(SETTLE);
  localparam logic [SW-1:0] SRELOAD = SW'(SETTLE - 1);

  state_t        state, nxt;
  logic          startl, sent, ready, load, adv, is_tx;
  logic [7:0]    data, tx_byte;
  logic [SW-1:0] scnt;

  jtframe_uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (tx_byte),
    .ready (ready),
    .tx    (uart_tx)
  );

  // A TX state loads once (sent=0), then advances when the byte has fully gone out
  always_comb begin
    nxt     = state;
    tx_byte = ASC_SP;
    is_tx   = 1'b0;
    case (state)
      S_IDLE:    if (start && !startl) nxt = S_SETTLE;
      S_SETTLE:  if (scnt == '0) nxt = S_CAPTURE;
      S_CAPTURE: nxt = S_HI;
      S_HI:      begin is_tx = 1'b1; tx_byte = hex_char(data[7:4]); end
      S_LO:      begin is_tx = 1'b1; tx_byte = hex_char(data[3:0]); end
      S_SP:      begin is_tx = 1'b1; tx_byte = ASC_SP; end
      S_CR:      begin is_tx = 1'b1; tx_byte = ASC_CR; end
      S_LF:      begin is_tx = 1'b1; tx_byte = ASC_LF; end
      default:   nxt = S_IDLE;
    endcase
    load = is_tx && ready && !sent;
    adv  = is_tx && ready && sent;
    if (adv) begin
      case (state)
        S_HI:    nxt = S_LO;
        S_LO:    nxt = S_SP;
        S_SP:    nxt = (st_addr == ADDR_LAST) ? S_CR : S_SETTLE;
        S_CR:    nxt = S_LF;
        default: nxt = S_IDLE;
      endcase
    end
    done = (state == S_LF) && adv;
    busy = (state != S_IDLE) && !done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      startl  <= 1'b0;
      sent    <= 1'b0;
      data    <= '0;
      scnt    <= '0;
      st_addr <= ADDR_FIRST;
    end else begin
      state  <= nxt;
      startl <= start;
      if (load)     sent <= 1'b1;
      else if (adv) sent <= 1'b0;
      case (state)
        S_IDLE: if (nxt == S_SETTLE) begin
          st_addr <= ADDR_FIRST;
          scnt    <= SRELOAD;
        end
        S_SETTLE:  if (scnt != '0) scnt <= scnt - 1'b1;
        S_CAPTURE: data <= st_dout;
        // Compare before increment so ADDR_LAST=8'hFF never wraps
        S_SP: if (adv && st_addr != ADDR_LAST) begin
          st_addr <= st_addr + 8'd1;
          scnt    <= SRELOAD;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jtframe_st_dump.sv
// Directed bench for jtframe_st_dump: three instances cover single-entry,
// multi-entry and top-of-range dumps, each fed by a registered status ROM.
module tb_jtframe_st_dump;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] dout  [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] addr  [3];
  logic       tx    [3];
  logic       busy  [3];
  logic       done  [3];

  int pass_n = 0, total_n = 0;
  int done_cnt [3] = '{0, 0, 0};
  int addr_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [7:0] a);
    return (a == 8'h40) ? 8'h3A : ~a;
  endfunction

  always @(posedge clk) for (int k = 0; k < 3; k++) dout[k] <= rom(addr[k]);
  always @(posedge clk) for (int k = 0; k < 3; k++)
    if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
  always @(negedge clk)
    if (busy[1] === 1'b1 && addr[1] > 8'd3) addr_bad <= addr_bad + 1;

  jtframe_st_dump #(.CLK_DIV(4), .ADDR_FIRST(8'h40), .ADDR_LAST(8'h40), .SETTLE(3)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .st_dout(dout[0]), .st_addr(addr[0]),
    .uart_tx(tx[0]), .busy(busy[0]), .done(done[0]));
  jtframe_st_dump #(.CLK_DIV(4), .ADDR_FIRST(8'h00), .ADDR_LAST(8'h03), .SETTLE(3)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .st_dout(dout[1]), .st_addr(addr[1]),
    .uart_tx(tx[1]), .busy(busy[1]), .done(done[1]));
  jtframe_st_dump #(.CLK_DIV(4), .ADDR_FIRST(8'hFE), .ADDR_LAST(8'hFF), .SETTLE(3)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .st_dout(dout[2]), .st_addr(addr[2]),
    .uart_tx(tx[2]), .busy(busy[2]), .done(done[2]));

  task automatic pulse(input int k);
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
  endtask

  // Receives one frame, sampling each bit window 4 times from the start-bit edge
  task automatic rx_byte(input int k, input logic [7:0] exp, input string nm);
    logic [9:0] bits;
    logic       samp;
    bit         bad = 0;
    int         w = 0;
    while (tx[k] !== 1'b0 && w < 3000) begin @(negedge clk); w++; end
    total_n++;
    if (tx[k] !== 1'b0) begin
      $display("FAIL %s start: tx=%b required 0 within 3000 cycles", nm, tx[k]);
      return;
    end
    pass_n++;
    for (int i = 0; i < 10; i++)
      for (int s = 0; s < 4; s++) begin
        if (i != 0 || s != 0) @(negedge clk);
        samp = tx[k];
        if (s == 0) bits[i] = samp;
        else if (samp !== bits[i]) bad = 1;
      end
    total_n++;
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || bad)
      $display("FAIL %s frame: start=%b stop=%b unstable=%0d required start=0 stop=1 unstable=0",
               nm, bits[0], bits[9], bad);
    else pass_n++;
    total_n++;
    if (bits[8:1] !== exp) $display("FAIL %s data: got %h required %h", nm, bits[8:1], exp);
    else pass_n++;
  endtask

  task automatic rx_seq(input int k, input logic [7:0] exp[$], input string nm);
    foreach (exp[i]) rx_byte(k, exp[i], $sformatf("%s[%0d]", nm, i));
  endtask

  task automatic wait_idle(input int k, input string nm);
    int w = 0;
    while (busy[k] !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    total_n++;
    if (busy[k] !== 1'b0) $display("FAIL %s idle: busy=%b required 0", nm, busy[k]);
    else pass_n++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] first [3] = '{8'h40, 8'h00, 8'hFE};
    int lows = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total_n++; if (tx[k] !== 1'b1) $display("FAIL reset tx%0d: got %b required 1", k, tx[k]); else pass_n++;
      total_n++; if (addr[k] !== first[k]) $display("FAIL reset addr%0d: got %h required %h", k, addr[k], first[k]); else pass_n++;
      total_n++; if (busy[k] !== 1'b0) $display("FAIL reset busy%0d: got %b required 0", k, busy[k]); else pass_n++;
      total_n++; if (done[k] !== 1'b0) $display("FAIL reset done%0d: got %b required 0", k, done[k]); else pass_n++;
    end
    rst = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (tx[k] !== 1'b1) lows++;
    end
    total_n++;
    if (lows != 0) $display("FAIL reset quiet: %0d non-idle tx samples required 0", lows); else pass_n++;
  endtask

  task automatic test_single();
    int d0 = done_cnt[0];
    longint t0, cyc;
    t0 = $time;
    pulse(0);
    rx_seq(0, '{8'h33, 8'h41, 8'h20, 8'h0D, 8'h0A}, "single");
    wait_idle(0, "single");
    cyc = ($time - t0) / 10;
    total_n++;
    if (cyc < 200 || cyc > 235) $display("FAIL single length: %0d cycles required 200..235", cyc); else pass_n++;
    total_n++;
    if (done_cnt[0] - d0 != 1) $display("FAIL single done: %0d pulses required 1", done_cnt[0] - d0); else pass_n++;
  endtask

  task automatic test_dump();
    int d0 = done_cnt[1], b0 = addr_bad;
    pulse(1);
    rx_seq(1, '{8'h46, 8'h46, 8'h20, 8'h46, 8'h45, 8'h20, 8'h46, 8'h44, 8'h20,
                8'h46, 8'h43, 8'h20, 8'h0D, 8'h0A}, "dump");
    wait_idle(1, "dump");
    total_n++; if (addr[1] !== 8'h03) $display("FAIL dump end addr: got %h required 03", addr[1]); else pass_n++;
    total_n++; if (addr_bad != b0) $display("FAIL dump addr range: %0d out-of-range required 0", addr_bad - b0); else pass_n++;
    total_n++; if (done_cnt[1] - d0 != 1) $display("FAIL dump done: %0d pulses required 1", done_cnt[1] - d0); else pass_n++;
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt[1], lows = 0;
    pulse(1);
    fork
      rx_seq(1, '{8'h46, 8'h46, 8'h20, 8'h46, 8'h45, 8'h20, 8'h46, 8'h44, 8'h20,
                  8'h46, 8'h43, 8'h20, 8'h0D, 8'h0A}, "b2b");
      begin
        repeat (60) @(negedge clk);
        total_n++; if (busy[1] !== 1'b1) $display("FAIL b2b busy: got %b required 1", busy[1]); else pass_n++;
        pulse(1);
      end
    join
    wait_idle(1, "b2b");
    repeat (300) begin @(negedge clk); if (tx[1] !== 1'b1) lows++; end
    total_n++; if (lows != 0) $display("FAIL b2b extra traffic: %0d low samples required 0", lows); else pass_n++;
    total_n++; if (done_cnt[1] - d0 != 1) $display("FAIL b2b done: %0d pulses required 1", done_cnt[1] - d0); else pass_n++;
  endtask

  task automatic test_reset_mid();
    int d0, w = 0;
    pulse(0);
    while (tx[0] !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    repeat (13) @(negedge clk);  // inside data bit 2 of '3' (a 0 bit)
    total_n++; if (tx[0] !== 1'b0) $display("FAIL abort pre tx: got %b required 0", tx[0]); else pass_n++;
    #1 rst = 1'b1;
    #1;
    total_n++; if (tx[0] !== 1'b1) $display("FAIL abort tx: got %b required 1", tx[0]); else pass_n++;
    total_n++; if (busy[0] !== 1'b0) $display("FAIL abort busy: got %b required 0", busy[0]); else pass_n++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    d0 = done_cnt[0];
    pulse(0);
    rx_seq(0, '{8'h33, 8'h41, 8'h20, 8'h0D, 8'h0A}, "resume");
    wait_idle(0, "resume");
    total_n++; if (done_cnt[0] - d0 != 1) $display("FAIL resume done: %0d pulses required 1", done_cnt[0] - d0); else pass_n++;
  endtask

  task automatic test_top_range();
    int d0 = done_cnt[2];
    pulse(2);
    rx_seq(2, '{8'h30, 8'h31, 8'h20, 8'h30, 8'h30, 8'h20, 8'h0D, 8'h0A}, "top");
    wait_idle(2, "top");
    total_n++; if (addr[2] !== 8'hFF) $display("FAIL top end addr: got %h required ff", addr[2]); else pass_n++;
    total_n++; if (done_cnt[2] - d0 != 1) $display("FAIL top done: %0d pulses required 1", done_cnt[2] - d0); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_dump();
    test_back_to_back();
    test_reset_mid();
    test_top_range();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
